// File: rtl/jtmikie_sdram_pkg.sv
// Shared types and constants for the Mikie SDRAM read scheduler.
package jtmikie_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [1:0]  SLOT_SCR  = 2'd0;
  localparam logic [1:0]  SLOT_OBJ  = 2'd1;
  localparam logic [1:0]  SLOT_SND  = 2'd2;
  localparam logic [1:0]  SLOT_MAIN = 2'd3;
  localparam int unsigned NSLOT     = 4;
  localparam int unsigned LINE_W    = 32;
  localparam int unsigned WORD_W    = 16;

  // Pick the slot to serve: main CPU first when prio_main, else 0 > 1 > 2 > 3.
  function automatic logic [1:0] pick_slot(input logic [NSLOT-1:0] pend,
                                            input logic             prio_main);
    logic [1:0] sel;
    sel = SLOT_MAIN;
    if (prio_main && pend[SLOT_MAIN]) sel = SLOT_MAIN;
    else if (pend[SLOT_SCR])          sel = SLOT_SCR;
    else if (pend[SLOT_OBJ])          sel = SLOT_OBJ;
    else if (pend[SLOT_SND])          sel = SLOT_SND;
    return sel;
  endfunction

endpackage

// File: rtl/jtmikie_sdram_line.sv
// One-line (32-bit) cache for a single scheduler slot: tag, valid and data.
module jtmikie_sdram_line
  import jtmikie_sdram_pkg::*;
#(
  parameter int unsigned TW = 21
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              fill_i,
  input  logic [TW-1:0]     fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i,
  input  logic              cs_i,
  input  logic [TW-1:0]     tag_i,
  output logic              ok_o,
  output logic [LINE_W-1:0] line_o
);

  logic [TW-1:0]     tag_q;
  logic              valid_q;
  logic [LINE_W-1:0] line_q;

  // Clear wins over fill so a download never leaves a stale line valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      line_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      tag_q   <= fill_tag_i;
      valid_q <= 1'b1;
      line_q  <= fill_line_i;
    end
  end

  // Zero-latency hit against registered state.
  always_comb begin
    ok_o   = cs_i & valid_q & (tag_q == tag_i);
    line_o = line_q;
  end

endmodule

// File: rtl/jtmikie_sdram_sched.sv
// Four-slot SDRAM read scheduler with per-slot line caches for Mikie.
module jtmikie_sdram_sched
  import jtmikie_sdram_pkg::*;
#(
  parameter int unsigned AW        = 22,
  parameter bit          PRIO_MAIN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              downloading,
  input  logic              slot0_cs,
  input  logic              slot1_cs,
  input  logic              slot2_cs,
  input  logic              slot3_cs,
  input  logic [AW-1:0]     slot0_addr,
  input  logic [AW-1:0]     slot1_addr,
  input  logic [AW-1:0]     slot2_addr,
  input  logic [AW-1:0]     slot3_addr,
  output logic              slot0_ok,
  output logic              slot1_ok,
  output logic              slot2_ok,
  output logic              slot3_ok,
  output logic [LINE_W-1:0] slot0_dout,
  output logic [LINE_W-1:0] slot1_dout,
  output logic [LINE_W-1:0] slot2_dout,
  output logic [LINE_W-1:0] slot3_dout,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              data_dst,
  input  logic              data_rdy,
  input  logic [WORD_W-1:0] data_read
);

  logic [NSLOT-1:0]  cs_v, ok_v, pend_v, fill_v;
  logic [AW-1:0]     addr_a [NSLOT];
  logic [LINE_W-1:0] dout_a [NSLOT];
  logic [1:0]        sel;
  logic [AW-1:0]     sel_addr;

  state_e            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              req_q, req_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  assign cs_v      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign addr_a[0] = slot0_addr;
  assign addr_a[1] = slot1_addr;
  assign addr_a[2] = slot2_addr;
  assign addr_a[3] = slot3_addr;

  for (genvar k = 0; k < NSLOT; k++) begin : g_line
    jtmikie_sdram_line #(.TW(AW-1)) u_line (
      .clk         (clk),
      .rstn        (rstn),
      .clr_i       (downloading),
      .fill_i      (fill_v[k]),
      .fill_tag_i  (addr_q[AW-1:1]),
      .fill_line_i (line_d),
      .cs_i        (cs_v[k]),
      .tag_i       (addr_a[k][AW-1:1]),
      .ok_o        (ok_v[k]),
      .line_o      (dout_a[k])
    );
  end

  assign {slot3_ok, slot2_ok, slot1_ok, slot0_ok} = ok_v;
  assign slot0_dout = dout_a[0];
  assign slot1_dout = dout_a[1];
  assign slot2_dout = dout_a[2];
  assign slot3_dout = dout_a[3];
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  // Arbiter: pending slots are requesting and not hitting their line.
  always_comb begin
    pend_v   = cs_v & ~ok_v;
    sel      = pick_slot(pend_v, 1'(PRIO_MAIN));
    sel_addr = addr_a[sel];
  end

  // Request registers and FSM state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      slot_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  // Next-state: latch request in IDLE, hold until ack, gather two words, fill.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    fill_v  = '0;
    case (state_q)
      IDLE: begin
        if (|pend_v) begin
          slot_d  = sel;
          addr_d  = sel_addr & ~AW'(1);
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (data_dst) begin
          if (cnt_q == 2'd0) line_d[WORD_W-1:0]      = data_read;
          if (cnt_q == 2'd1) line_d[LINE_W-1:WORD_W] = data_read;
          if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
        end
        if (data_rdy) begin
          if (cnt_d == 2'd2) fill_v[slot_q] = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The downloader owns the SDRAM: abandon any fetch.
    if (downloading) begin
      state_d = IDLE;
      req_d   = 1'b0;
      fill_v  = '0;
    end
  end

endmodule

// File: tb/tb_jtmikie_sdram_sched.sv
// Directed bench for jtmikie_sdram_sched: vector table plus corner-case sequences.
module tb_jtmikie_sdram_sched;

  logic        clk = 1'b0;
  logic        rstn, downloading;
  logic [3:0]  cs;
  logic [21:0] sa [4];
  logic        ack, dst, rdy;
  logic [15:0] rd;

  wire         req_a, req_b;
  wire  [21:0] addr_oa, addr_ob;
  wire  [3:0]  ok_a, ok_b;
  wire  [31:0] dout_a [4];
  wire  [31:0] dout_b [4];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtmikie_sdram_sched u_dut_a (
    .clk(clk), .rstn(rstn), .downloading(downloading),
    .slot0_cs(cs[0]), .slot1_cs(cs[1]), .slot2_cs(cs[2]), .slot3_cs(cs[3]),
    .slot0_addr(sa[0]), .slot1_addr(sa[1]), .slot2_addr(sa[2]), .slot3_addr(sa[3]),
    .slot0_ok(ok_a[0]), .slot1_ok(ok_a[1]), .slot2_ok(ok_a[2]), .slot3_ok(ok_a[3]),
    .slot0_dout(dout_a[0]), .slot1_dout(dout_a[1]), .slot2_dout(dout_a[2]), .slot3_dout(dout_a[3]),
    .sdram_req(req_a), .sdram_addr(addr_oa), .sdram_ack(ack),
    .data_dst(dst), .data_rdy(rdy), .data_read(rd)
  );

  jtmikie_sdram_sched #(.PRIO_MAIN(1'b0)) u_dut_b (
    .clk(clk), .rstn(rstn), .downloading(downloading),
    .slot0_cs(cs[0]), .slot1_cs(cs[1]), .slot2_cs(cs[2]), .slot3_cs(cs[3]),
    .slot0_addr(sa[0]), .slot1_addr(sa[1]), .slot2_addr(sa[2]), .slot3_addr(sa[3]),
    .slot0_ok(ok_b[0]), .slot1_ok(ok_b[1]), .slot2_ok(ok_b[2]), .slot3_ok(ok_b[3]),
    .slot0_dout(dout_b[0]), .slot1_dout(dout_b[1]), .slot2_dout(dout_b[2]), .slot3_dout(dout_b[3]),
    .sdram_req(req_b), .sdram_addr(addr_ob), .sdram_ack(ack),
    .data_dst(dst), .data_rdy(rdy), .data_read(rd)
  );

  typedef struct {
    int          slot;
    logic [21:0] addr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [21:0] exp_addr;
    logic [31:0] exp_line;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for DUT A to raise sdram_req; ends on a negedge.
  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = req_a;
    end
    check("req_seen", 64'(seen), 64'd1);
  endtask

  // Ack the pending request and return a two-word burst, rdy on the second word.
  task automatic serve(input logic [15:0] w0, input logic [15:0] w1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; dst = 1'b1; rd = w0;
    @(negedge clk);
    rd = w1; rdy = 1'b1;
    @(negedge clk);
    dst = 1'b0; rdy = 1'b0;
    #1;
  endtask

  initial begin
    vt[0] = '{3, 22'h000104, 16'h1234, 16'hABCD, 22'h000104, 32'hABCD1234};
    vt[1] = '{0, 22'h000201, 16'h5555, 16'hAAAA, 22'h000200, 32'hAAAA5555};
    vt[2] = '{1, 22'h3FFFFF, 16'h0001, 16'hFFFF, 22'h3FFFFE, 32'hFFFF0001};
    vt[3] = '{2, 22'h000000, 16'hBEEF, 16'hDEAD, 22'h000000, 32'hDEADBEEF};

    rstn = 1'b0; downloading = 1'b0; cs = 4'hF;
    for (int k = 0; k < 4; k++) sa[k] = '0;
    ack = 1'b0; dst = 1'b0; rdy = 1'b0; rd = '0;

    // Reset state
    #12;
    check("rst_req",  64'(req_a),     64'd0);
    check("rst_addr", 64'(addr_oa),   64'd0);
    check("rst_ok",   64'(ok_a),      64'd0);
    check("rst_dout", 64'(dout_a[3]), 64'd0);
    @(negedge clk);
    cs = 4'h0; rstn = 1'b1;

    // Table: single misses on each slot, including odd and top-of-range addresses
    for (int i = 0; i < 4; i++) begin
      sa[vt[i].slot] = vt[i].addr;
      cs = 4'(1 << vt[i].slot);
      #1;
      check("vec_miss", 64'(ok_a[vt[i].slot]), 64'd0);
      wait_req();
      check("vec_sdram_addr", 64'(addr_oa), 64'(vt[i].exp_addr));
      serve(vt[i].w0, vt[i].w1);
      check("vec_ok",   64'(ok_a[vt[i].slot]),   64'd1);
      check("vec_dout", 64'(dout_a[vt[i].slot]), 64'(vt[i].exp_line));
      cs = 4'h0;
    end

    // Odd word of the same line hits with no new request
    cs = 4'b1000; sa[3] = 22'h000105;
    #1;
    check("odd_word_ok", 64'(ok_a[3]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("odd_word_no_req", 64'(req_a), 64'd0);
    end
    cs = 4'hF;
    #1;
    check("all_lines_kept", 64'(ok_a), 64'hF);
    cs = 4'h0;

    // Priority: slots 0 and 3 miss together
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("prio_rst_req", 64'(req_a), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    sa[0] = 22'h001000; sa[3] = 22'h003000; cs = 4'b1001;
    wait_req();
    check("prio_a_first", 64'(addr_oa), 64'h003000);
    check("prio_b_first", 64'(addr_ob), 64'h001000);
    serve(16'h0001, 16'h0002);
    check("prio_a_ok1", 64'(ok_a), 64'b1000);
    check("prio_b_ok1", 64'(ok_b), 64'b0001);
    wait_req();
    check("prio_a_second", 64'(addr_oa), 64'h001000);
    check("prio_b_second", 64'(addr_ob), 64'h003000);
    serve(16'h0003, 16'h0004);
    check("prio_a_ok2",   64'(ok_a), 64'b1001);
    check("prio_b_ok2",   64'(ok_b), 64'b1001);
    check("prio_a_dout3", 64'(dout_a[3]), 64'h00020001);
    check("prio_a_dout0", 64'(dout_a[0]), 64'h00040003);
    check("prio_b_dout0", 64'(dout_b[0]), 64'h00020001);
    cs = 4'h0;

    // Address change mid-fetch: fill keeps the latched tag
    sa[1] = 22'h002000; cs = 4'b0010;
    wait_req();
    check("mid_addr", 64'(addr_oa), 64'h002000);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; sa[1] = 22'h002010; dst = 1'b1; rd = 16'h7777;
    @(negedge clk);
    rd = 16'h8888; rdy = 1'b1;
    @(negedge clk);
    dst = 1'b0; rdy = 1'b0;
    #1;
    check("mid_new_miss", 64'(ok_a[1]), 64'd0);
    sa[1] = 22'h002000;
    #1;
    check("mid_old_tag_ok", 64'(ok_a[1]),   64'd1);
    check("mid_old_dout",   64'(dout_a[1]), 64'h88887777);
    @(negedge clk);
    check("mid_hit_no_req", 64'(req_a), 64'd0);
    sa[1] = 22'h002010;
    wait_req();
    check("mid_rereq_addr", 64'(addr_oa), 64'h002010);
    serve(16'h0009, 16'h000A);
    check("mid_ok",   64'(ok_a[1]),   64'd1);
    check("mid_dout", 64'(dout_a[1]), 64'h000A0009);

    // Download abort during WAIT
    sa[2] = 22'h004000; cs = 4'b0110;
    wait_req();
    check("dl_addr", 64'(addr_oa), 64'h004000);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; dst = 1'b1; rd = 16'h1111;
    @(negedge clk);
    dst = 1'b0; downloading = 1'b1;
    @(negedge clk);
    check("dl_req", 64'(req_a), 64'd0);
    check("dl_ok",  64'(ok_a),  64'd0);
    dst = 1'b1; rdy = 1'b1; rd = 16'h2222;
    @(negedge clk);
    dst = 1'b0; rdy = 1'b0;
    check("dl_no_req", 64'(req_a), 64'd0);
    cs = 4'b0100; downloading = 1'b0;
    #1;
    check("dl_no_fill", 64'(ok_a[2]), 64'd0);
    wait_req();
    check("dl_rereq_addr", 64'(addr_oa), 64'h004000);
    serve(16'h3333, 16'h4444);
    check("dl_ok_after",   64'(ok_a[2]),   64'd1);
    check("dl_dout_after", 64'(dout_a[2]), 64'h44443333);
    cs = 4'h0;

    // Short burst: one word only
    sa[0] = 22'h005000; cs = 4'b0001;
    wait_req();
    check("short_addr", 64'(addr_oa), 64'h005000);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; dst = 1'b1; rdy = 1'b1; rd = 16'h5151;
    @(negedge clk);
    dst = 1'b0; rdy = 1'b0;
    #1;
    check("short_invalid", 64'(ok_a[0]), 64'd0);
    wait_req();
    check("short_rereq_addr", 64'(addr_oa), 64'h005000);
    serve(16'h0606, 16'h0707);
    check("short_ok",   64'(ok_a[0]),   64'd1);
    check("short_dout", 64'(dout_a[0]), 64'h07070606);

    // Reset while in REQ drops the request asynchronously
    sa[3] = 22'h006000; cs = 4'b1001;
    wait_req();
    check("rstreq_addr", 64'(addr_oa), 64'h006000);
    #2 rstn = 1'b0;
    #1;
    check("rstreq_req",  64'(req_a),   64'd0);
    check("rstreq_ok",   64'(ok_a),    64'd0);
    check("rstreq_addr0",64'(addr_oa), 64'd0);
    @(negedge clk);
    cs = 4'h0; rstn = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
